// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register with valid/ready
// handoff to decode, branch/jump redirect with flush, sticky halt/resume, fetch counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        misalign_err,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic        misalign_q, misalign_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        load;
  logic        running;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: redirect > halt_req > resume
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = ST_RUN;
    end else if (halt_req) begin
      state_d = ST_HALT;
    end else if (resume && (state_q == ST_HALT)) begin
      state_d = ST_RUN;
    end
  end

  // Output/control decode from current state
  always_comb begin
    running = (state_q == ST_RUN);
    halted  = (state_q == ST_HALT);
    load    = running && !redirect_valid && !halt_req && (!if_valid_q || id_ready);
  end

  // Datapath next values
  always_comb begin
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    fetch_count_d = fetch_count_q;
    misalign_d    = 1'b0;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      if_valid_d = 1'b0;
      misalign_d = |redirect_pc[1:0];
    end else if (load) begin
      if_instr_d    = imem_instr;
      if_pc_d       = pc_q;
      if_pc_plus4_d = pc_q + 32'd4;
      if_valid_d    = 1'b1;
      pc_d          = pc_q + 32'd4;
      fetch_count_d = fetch_count_q + 32'd1;
    end else if (if_valid_q && id_ready) begin
      // Drain only; payload fields keep their last value.
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr    = pc_q;
  assign if_valid     = if_valid_q;
  assign if_instr     = if_instr_q;
  assign if_pc        = if_pc_q;
  assign if_pc_plus4  = if_pc_plus4_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table from the test plan, then randomized
// stimulus compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        resume;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        misalign_err;
  logic        halted;
  logic [31:0] fetch_count;

  int unsigned n_pass;
  int unsigned n_total;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .resume         (resume),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .misalign_err   (misalign_err),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64 KB instruction memory: word i holds 0x1000_0000 + i, aliased on bits [15:2]
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + ((addr / 4) % 16384);
  endfunction

  assign imem_instr = mem_word(imem_addr);

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_ifpc, m_plus4, m_cnt;
  logic        m_valid, m_mis, m_halt;

  task automatic model_edge();
    logic ld;
    if (!rst_n) begin
      m_pc = RST_PC; m_valid = 1'b0; m_instr = '0; m_ifpc = '0;
      m_plus4 = '0; m_mis = 1'b0; m_halt = 1'b0; m_cnt = '0;
    end else begin
      ld = !m_halt && !redirect_valid && !halt_req && (!m_valid || id_ready);
      m_mis = 1'b0;
      if (redirect_valid) begin
        m_pc    = redirect_pc - (redirect_pc % 4);
        m_valid = 1'b0;
        m_mis   = (redirect_pc % 4) != 0;
        m_halt  = 1'b0;
      end else begin
        if (ld) begin
          m_instr = mem_word(m_pc);
          m_ifpc  = m_pc;
          m_plus4 = m_pc + 4;
          m_valid = 1'b1;
          m_pc    = m_pc + 4;
          m_cnt   = m_cnt + 1;
        end else if (m_valid && id_ready) begin
          m_valid = 1'b0;
        end
        if (halt_req) m_halt = 1'b1;
        else if (resume) m_halt = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".if_valid"},     {31'b0, if_valid},     {31'b0, m_valid});
    chk({tag, ".if_instr"},     if_instr,              m_instr);
    chk({tag, ".if_pc"},        if_pc,                 m_ifpc);
    chk({tag, ".if_pc_plus4"},  if_pc_plus4,           m_plus4);
    chk({tag, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, m_mis});
    chk({tag, ".halted"},       {31'b0, halted},       {31'b0, m_halt});
    chk({tag, ".fetch_count"},  fetch_count,           m_cnt);
    chk({tag, ".imem_addr"},    imem_addr,             m_pc);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic        rst_n, rv, hr, rs, idr;
    logic [31:0] rpc;
    logic        e_valid, e_mis, e_halt;
    logic [31:0] e_ifpc, e_cnt, e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rv, input logic [31:0] rpc,
                     input logic hr, input logic rs, input logic idr,
                     input logic ev, input logic [31:0] epc, input logic emis,
                     input logic eh, input logic [31:0] ecnt, input logic [31:0] eaddr);
    vec_t v;
    v.rst_n = r; v.rv = rv; v.rpc = rpc; v.hr = hr; v.rs = rs; v.idr = idr;
    v.e_valid = ev; v.e_ifpc = epc; v.e_mis = emis; v.e_halt = eh;
    v.e_cnt = ecnt; v.e_addr = eaddr;
    vecs.push_back(v);
  endtask

  initial begin
    string tag;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt_req = 1'b0; resume = 1'b0; id_ready = 1'b1;
    m_pc = RST_PC; m_valid = 1'b0; m_instr = '0; m_ifpc = '0;
    m_plus4 = '0; m_mis = 1'b0; m_halt = 1'b0; m_cnt = '0;

    //  rst rv rpc            hr rs idr | valid if_pc         mis halt cnt addr
    add(0, 0, 32'h0,          0, 0, 1,   0, 32'h0,          0, 0, 0,  32'h0);
    add(1, 0, 32'h0,          0, 0, 1,   1, 32'h0,          0, 0, 1,  32'h4);
    add(1, 0, 32'h0,          0, 0, 1,   1, 32'h4,          0, 0, 2,  32'h8);
    add(1, 0, 32'h0,          0, 0, 1,   1, 32'h8,          0, 0, 3,  32'hC);
    add(1, 0, 32'h0,          0, 0, 0,   1, 32'h8,          0, 0, 3,  32'hC);
    add(1, 0, 32'h0,          0, 0, 0,   1, 32'h8,          0, 0, 3,  32'hC);
    add(1, 0, 32'h0,          0, 0, 0,   1, 32'h8,          0, 0, 3,  32'hC);
    add(1, 0, 32'h0,          0, 0, 1,   1, 32'hC,          0, 0, 4,  32'h10);
    add(1, 1, 32'h42,         0, 0, 0,   0, 32'hC,          1, 0, 4,  32'h40);
    add(1, 0, 32'h0,          0, 0, 0,   1, 32'h40,         0, 0, 5,  32'h44);
    add(1, 0, 32'h0,          0, 0, 1,   1, 32'h44,         0, 0, 6,  32'h48);
    add(1, 1, 32'h0,          0, 0, 1,   0, 32'h44,         0, 0, 6,  32'h0);
    add(1, 0, 32'h0,          0, 0, 1,   1, 32'h0,          0, 0, 7,  32'h4);
    add(1, 0, 32'h0,          0, 0, 1,   1, 32'h4,          0, 0, 8,  32'h8);
    add(1, 0, 32'h0,          1, 0, 1,   0, 32'h4,          0, 1, 8,  32'h8);
    for (int i = 0; i < 5; i++)
      add(1, 0, 32'h0,        0, 0, 1,   0, 32'h4,          0, 1, 8,  32'h8);
    add(1, 0, 32'h0,          0, 1, 1,   0, 32'h4,          0, 0, 8,  32'h8);
    add(1, 0, 32'h0,          0, 0, 1,   1, 32'h8,          0, 0, 9,  32'hC);
    add(1, 1, 32'hFFFF_FFFC,  0, 0, 1,   0, 32'h8,          0, 0, 9,  32'hFFFF_FFFC);
    add(1, 0, 32'h0,          0, 0, 1,   1, 32'hFFFF_FFFC,  0, 0, 10, 32'h0);
    add(1, 0, 32'h0,          0, 0, 1,   1, 32'h0,          0, 0, 11, 32'h4);
    add(1, 0, 32'h0,          1, 0, 0,   1, 32'h0,          0, 1, 11, 32'h4);
    add(1, 0, 32'h0,          0, 0, 0,   1, 32'h0,          0, 1, 11, 32'h4);
    add(0, 0, 32'h0,          0, 0, 0,   0, 32'h0,          0, 0, 0,  32'h0);
    add(1, 0, 32'h0,          0, 0, 1,   1, 32'h0,          0, 0, 1,  32'h4);
    add(1, 0, 32'h0,          1, 1, 0,   1, 32'h0,          0, 1, 1,  32'h4);
    add(1, 0, 32'h0,          0, 1, 0,   1, 32'h0,          0, 0, 1,  32'h4);
    add(1, 0, 32'h0,          0, 0, 1,   1, 32'h4,          0, 0, 2,  32'h8);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      halt_req = vecs[i].hr; resume = vecs[i].rs; id_ready = vecs[i].idr;
      tag = $sformatf("vec%0d", i);
      step(tag);
      chk({tag, ".tbl_valid"}, {31'b0, if_valid},     {31'b0, vecs[i].e_valid});
      chk({tag, ".tbl_if_pc"}, if_pc,                 vecs[i].e_ifpc);
      chk({tag, ".tbl_mis"},   {31'b0, misalign_err}, {31'b0, vecs[i].e_mis});
      chk({tag, ".tbl_halt"},  {31'b0, halted},       {31'b0, vecs[i].e_halt});
      chk({tag, ".tbl_count"}, fetch_count,           vecs[i].e_cnt);
      chk({tag, ".tbl_addr"},  imem_addr,             vecs[i].e_addr);
    end

    // Wrap: the word after 0xFFFF_FFFC reports pc_plus4 of 0
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF9; halt_req = 1'b0;
    resume = 1'b0; id_ready = 1'b1; rst_n = 1'b1;
    step("wrap0");
    chk("wrap0.misalign", {31'b0, misalign_err}, 32'd1);
    redirect_valid = 1'b0;
    step("wrap1");
    chk("wrap1.if_pc",    if_pc,       32'hFFFF_FFF8);
    chk("wrap1.plus4",    if_pc_plus4, 32'hFFFF_FFFC);
    chk("wrap1.misalign", {31'b0, misalign_err}, 32'd0);
    step("wrap2");
    step("wrap3");
    chk("wrap3.if_pc",    if_pc,       32'h0);
    chk("wrap3.instr",    if_instr,    32'h1000_0000);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n          = ($urandom_range(0, 299) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom;
      if ($urandom_range(0, 3) != 0) redirect_pc = redirect_pc & 32'h0001_FFFC;
      halt_req       = ($urandom_range(0, 15) == 0);
      resume         = ($urandom_range(0, 3) == 0);
      id_ready       = ($urandom_range(0, 9) < 7);
      step($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the Mini-MIPS pipeline. Holds the program counter, drives the word-aligned byte address into the combinational 64 KB instruction memory, captures the returned instruction into the IF/ID pipeline register and hands it to decode over a valid/ready handshake. It also handles branch/jump redirects with flush, a sticky halt/resume state machine, and a fetch counter.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- clk  in  1  rising-edge clock, sole clock
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- imem_addr  out  32  byte address to instruction memory; memory uses bits [15:2]
- imem_instr  in  32  instruction word, combinational from imem_addr, same cycle
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  32  redirect target byte address
- halt_req  in  1  stop fetching (sticky)
- resume  in  1  leave HALT and continue at current PC
- id_ready  in  1  decode accepts the IF/ID contents this cycle
- if_valid  out  1  IF/ID register holds a valid instruction
- if_instr  out  32  fetched instruction
- if_pc  out  32  address of if_instr
- if_pc_plus4  out  32  if_pc + 4 (mod 2^32)
- misalign_err  out  1  one-cycle pulse: last redirect target had bits [1:0] ≠ 0
- halted  out  1  state == HALT
- fetch_count  out  32  number of instructions loaded into IF/ID since reset

## Operation
- State machine: RUN, HALT. Reset → RUN.
- imem_addr = pc (combinational, registered pc only).
- load = (state==RUN) && !redirect_valid && !halt_req && (!if_valid || id_ready).
- Priority per cycle: reset > redirect > halt_req > resume > load/drain.
- Redirect (any state): pc <= {redirect_pc[31:2],2'b00}; if_valid <= 0 (flush, even if id_ready=1 that cycle, the held instruction is consumed, no new load); misalign_err <= |redirect_pc[1:0]; state <= RUN (also exits HALT). fetch_count unchanged.
- halt_req in RUN without redirect: state <= HALT, no load that cycle. In HALT no loads; IF/ID still drains: if_valid && id_ready → if_valid <= 0.
- resume in HALT (no redirect, no halt_req): state <= RUN; loading restarts next cycle from unchanged pc. resume in RUN ignored; halt_req+resume together → HALT.
- On load: if_instr <= imem_instr; if_pc <= pc; if_pc_plus4 <= pc+4; if_valid <= 1; pc <= pc+4; fetch_count <= fetch_count+1.
- Not loading, not redirecting: if_valid && id_ready → if_valid <= 0; else IF/ID and pc hold (stall). if_instr/if_pc hold when if_valid clears.
- Arithmetic: pc+4 and fetch_count wrap mod 2^32 (0xFFFF_FFFC → 0x0000_0000). PC above 0xFFFF is passed through; memory aliases on bits [15:2].
- misalign_err is 0 in every cycle not immediately following a misaligned redirect.

## Timing
- Reset values: pc=RESET_PC, if_valid=0, if_instr=32'h0000_0000 (NOP), if_pc=0, if_pc_plus4=0, misalign_err=0, halted=0, fetch_count=0, state=RUN.
- First edge after rst_n rises: loads instr at RESET_PC; if_valid=1 one cycle after reset release.
- Fetch latency 1 cycle (pc → IF/ID). Throughput 1 instr/cycle with id_ready held high.
- Redirect: one bubble; target instruction in IF/ID 2 edges after redirect edge.
- rst_n low mid-operation (including HALT or during redirect): all state returns to reset values at that edge; outputs beyond reset are don't-care-free.
- Inputs sampled only on rising clk; no combinational path from any input to outputs except none (imem_addr depends on pc only).

## Test plan
- Reset, RESET_PC=0, memory word i = 0x1000_0000+i, id_ready=1 for 4 cycles → if_pc 0,4,8,12; if_instr 0x1000_0000..0x1000_0003; fetch_count=4.
- id_ready=0 for 3 cycles with if_valid=1 at if_pc=8 → if_instr/if_pc/pc frozen, fetch_count unchanged; release → next if_pc=12, no duplicate or skip.
- redirect_valid with redirect_pc=0x0000_0042 while id_ready=0 → next cycle if_valid=0, misalign_err=1, imem_addr=0x40; following cycle if_pc=0x40, misalign_err=0.
- halt_req pulse at if_pc=4, id_ready=1 → halted=1, IF/ID drains to if_valid=0, no fetch for 5 cycles; resume → if_pc=8 loaded next edge.
- Redirect to 0xFFFF_FFFC, run 2 cycles → if_pc 0xFFFF_FFFC then 0x0000_0000, if_pc_plus4 of first = 0.
- Assert rst_n=0 while HALT with if_valid=1 → all outputs at reset values next edge, halted=0.
